branch_predictor: RTL and testbench

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/mpc_pkg.sv | 27 ++
 rtl/pred_queue.sv | 54 +++++
 rtl/branch_predictor.sv | 100 ++++++++++
 tb/tb_branch_predictor.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mpc_pkg.sv
// Shared microprogram-control definitions: MIR TYPE codes, prediction type codes,
// and the 2-bit saturating counter behaviour used by the predictor and the checker.
package mpc_pkg;

   localparam logic [6:0] T_JCOND = 7'b1000001;
   localparam logic [6:0] T_JCY   = 7'b1010000;

   localparam logic [1:0] COND_JZE = 2'b01;
   localparam logic [1:0] COND_JNE = 2'b10;

   typedef enum logic [1:0] {
      PT_JCY = 2'b00,
      PT_JZE = 2'b01,
      PT_JNE = 2'b10
   } pred_type_e;

   // Weakly not-taken.
   localparam logic [1:0] CTR_RESET = 2'b01;

   function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic up);
      if (up)
         return (ctr == 2'b11) ? ctr : ctr + 2'd1;
      else
         return (ctr == 2'b00) ? ctr : ctr - 2'd1;
   endfunction

endpackage

// File: rtl/pred_queue.sv
// In-flight prediction FIFO: push at tail, pop at head, flush discards all entries.
// head_data reads as zero while the queue is empty.
module pred_queue #(
   parameter int WIDTH = 7,
   parameter int DEPTH = 2
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         push,
   input  logic                         pop,
   input  logic                         flush,
   input  logic [WIDTH-1:0]             push_data,
   output logic [WIDTH-1:0]             head_data,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    wr_ptr;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= next_ptr(wr_ptr);
         if (pop)
            rd_ptr <= next_ptr(rd_ptr);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // When full, a simultaneous pop reads the old head before this write lands.
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= push_data;
   end

   assign head_data = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/branch_predictor.sv
// Microbranch predictor: 2-bit saturating counters indexed by microaddress,
// with an in-flight queue of predictions awaiting resolution by the checker.
module branch_predictor
   import mpc_pkg::*;
#(
   parameter int TABLE_BITS = 4,
   parameter int Q_DEPTH    = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       fetch_valid,
   input  logic [6:0] fetch_T,
   input  logic [1:0] fetch_cond,
   input  logic [7:0] fetch_addr,
   output logic       pred_taken,
   output logic       stall,
   output logic [1:0] pred_type,
   output logic       last_pred,
   output logic       pending,
   input  logic       checked,
   input  logic       incorrect_pred,
   input  logic       correct_pred
);

   localparam int unsigned ENTRIES = 1 << TABLE_BITS;
   localparam int EW = TABLE_BITS + 3;
   localparam int CW = $clog2(Q_DEPTH + 1);

   logic [1:0]            ctr [ENTRIES];
   logic [TABLE_BITS-1:0] idx;
   logic                  is_branch;
   pred_type_e            ftype;

   logic [EW-1:0]         push_data;
   logic [EW-1:0]         head_data;
   logic [CW-1:0]         count;
   logic [TABLE_BITS-1:0] head_idx;
   logic                  full;
   logic                  nonempty;
   logic                  do_push;
   logic                  do_pop;
   logic                  flush;
   logic                  unused_addr_bits;

   assign idx              = fetch_addr[TABLE_BITS-1:0];
   assign unused_addr_bits = ^fetch_addr[7:TABLE_BITS];

   always_comb begin
      is_branch = 1'b0;
      ftype     = PT_JCY;
      if (fetch_valid) begin
         if (fetch_T == T_JCOND && (fetch_cond == COND_JZE || fetch_cond == COND_JNE)) begin
            is_branch = 1'b1;
            ftype     = pred_type_e'(fetch_cond);
         end else if (fetch_T == T_JCY) begin
            is_branch = 1'b1;
         end
      end
   end

   assign pred_taken = is_branch & ctr[idx][1];

   assign full     = (count == CW'(Q_DEPTH));
   assign nonempty = (count != '0);
   assign stall    = is_branch & full & ~checked;
   assign do_pop   = checked & nonempty;
   // A misprediction squashes everything younger, including this cycle's fetch.
   assign flush    = do_pop & incorrect_pred;
   assign do_push  = is_branch & ~stall & ~flush;

   assign push_data = {ftype, pred_taken, idx};
   assign head_idx  = head_data[TABLE_BITS-1:0];
   assign pred_type = head_data[EW-1 -: 2];
   assign last_pred = head_data[TABLE_BITS];
   assign pending   = nonempty;

   pred_queue #(
      .WIDTH (EW),
      .DEPTH (Q_DEPTH)
   ) u_queue (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (do_push),
      .pop       (do_pop),
      .flush     (flush),
      .push_data (push_data),
      .head_data (head_data),
      .count     (count)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < ENTRIES; i++)
            ctr[i[TABLE_BITS-1:0]] <= CTR_RESET;
      end else if (do_pop) begin
         ctr[head_idx] <= sat_update(ctr[head_idx], correct_pred);
      end
   end

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

  localparam logic [6:0] JC = 7'b1000001;
  localparam logic [6:0] JY = 7'b1010000;

  localparam int unsigned S_PT    = 0;
  localparam int unsigned S_STALL = 1;
  localparam int unsigned S_TYPE  = 2;
  localparam int unsigned S_LAST  = 3;
  localparam int unsigned S_PEND  = 4;

  logic       clk;
  logic       rst_n;
  logic       fetch_valid;
  logic [6:0] fetch_T;
  logic [1:0] fetch_cond;
  logic [7:0] fetch_addr;
  logic       pred_taken;
  logic       stall;
  logic [1:0] pred_type;
  logic       last_pred;
  logic       pending;
  logic       checked;
  logic       incorrect_pred;
  logic       correct_pred;

  typedef struct {
    int unsigned cyc;
    int unsigned sig;
    logic [1:0]  val;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;

  branch_predictor #(
    .TABLE_BITS (4),
    .Q_DEPTH    (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_valid    (fetch_valid),
    .fetch_T        (fetch_T),
    .fetch_cond     (fetch_cond),
    .fetch_addr     (fetch_addr),
    .pred_taken     (pred_taken),
    .stall          (stall),
    .pred_type      (pred_type),
    .last_pred      (last_pred),
    .pending        (pending),
    .checked        (checked),
    .incorrect_pred (incorrect_pred),
    .correct_pred   (correct_pred)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [1:0] sel(input int unsigned sig);
    case (sig)
      S_PT:    return {1'b0, pred_taken};
      S_STALL: return {1'b0, stall};
      S_TYPE:  return pred_type;
      S_LAST:  return {1'b0, last_pred};
      default: return {1'b0, pending};
    endcase
  endfunction

  always @(negedge clk) begin
    logic [1:0] got;
    for (int unsigned k = sb.size(); k > 0; k--) begin
      if (sb[k-1].cyc == cyc) begin
        got = sel(sb[k-1].sig);
        checks++;
        if (got !== sb[k-1].val) begin
          errors++;
          $display("FAIL %s cyc=%0d got=%0d expected=%0d", sb[k-1].name, cyc, got, sb[k-1].val);
        end
        sb.delete(k-1);
      end
    end
  end

  task automatic exp_push(input int unsigned off, input int unsigned sig,
                          input logic [1:0] val, input string name);
    exp_t e;
    e.cyc  = cyc + off;
    e.sig  = sig;
    e.val  = val;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    fetch_valid    = 1'b0;
    fetch_T        = '0;
    fetch_cond     = '0;
    fetch_addr     = '0;
    checked        = 1'b0;
    incorrect_pred = 1'b0;
    correct_pred   = 1'b0;
  endtask

  task automatic fetch(input logic [6:0] t, input logic [1:0] c, input logic [7:0] a);
    fetch_valid = 1'b1;
    fetch_T     = t;
    fetch_cond  = c;
    fetch_addr  = a;
  endtask

  task automatic resolve(input logic corr, input logic inc);
    checked        = 1'b1;
    correct_pred   = corr;
    incorrect_pred = inc;
  endtask

  task automatic fr(input logic [7:0] a, input logic corr, input logic ept, input string tag);
    tick();
    fetch(JC, 2'b01, a);
    exp_push(0, S_PT,   {1'b0, ept}, {tag, "_pt"});
    exp_push(0, S_PEND, 2'd0,        {tag, "_empty"});
    exp_push(1, S_PEND, 2'd1,        {tag, "_pend"});
    exp_push(1, S_TYPE, 2'b01,       {tag, "_type"});
    exp_push(1, S_LAST, {1'b0, ept}, {tag, "_last"});
    tick();
    resolve(corr, 1'b0);
  endtask

  initial begin
    rst_n          = 1'b0;
    fetch_valid    = 1'b0;
    fetch_T        = '0;
    fetch_cond     = '0;
    fetch_addr     = '0;
    checked        = 1'b0;
    incorrect_pred = 1'b0;
    correct_pred   = 1'b0;
    tick();
    tick();
    tick();
    rst_n = 1'b1;
    exp_push(0, S_PEND,  2'd0, "rst_pend");
    exp_push(0, S_TYPE,  2'd0, "rst_type");
    exp_push(0, S_LAST,  2'd0, "rst_last");
    exp_push(0, S_STALL, 2'd0, "rst_stall");
    checks++;
    if (pending !== 1'b0) begin
      errors++;
      $display("FAIL d_rst_pend got=%0d expected=0", pending);
    end
    checks++;
    if (pred_type !== 2'b00) begin
      errors++;
      $display("FAIL d_rst_type got=%0d expected=0", pred_type);
    end
    checks++;
    if (last_pred !== 1'b0) begin
      errors++;
      $display("FAIL d_rst_last got=%0d expected=0", last_pred);
    end
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL d_rst_stall got=%0d expected=0", stall);
    end

    fr(8'h05, 1'b1, 1'b0, "a5_0");
    fr(8'h05, 1'b1, 1'b1, "a5_1");
    fr(8'h05, 1'b1, 1'b1, "a5_2");
    fr(8'h05, 1'b0, 1'b1, "a5_sat_hi");
    fr(8'h05, 1'b0, 1'b1, "a5_4");
    fr(8'h05, 1'b0, 1'b0, "a5_5");
    fr(8'h05, 1'b0, 1'b0, "a5_6");
    fr(8'h05, 1'b1, 1'b0, "a5_sat_lo");
    fr(8'h05, 1'b1, 1'b0, "a5_8");
    fr(8'h05, 1'b1, 1'b1, "a5_9");

    tick(); fetch(JC, 2'b10, 8'h0A);
    tick(); fetch(JC, 2'b10, 8'h0B);
    exp_push(0, S_PEND, 2'd1, "q_pend1");
    tick(); fetch(JY, 2'b00, 8'h0C);
    exp_push(0, S_STALL, 2'd1, "q_stall");
    exp_push(0, S_PT,    2'd0, "q_stall_pt");
    tick(); fetch(JY, 2'b00, 8'h0C);
    exp_push(0, S_STALL, 2'd1, "q_stall_again");
    exp_push(0, S_TYPE,  2'b10, "q_head_jne");
    tick(); fetch(JY, 2'b00, 8'h0C); resolve(1'b0, 1'b0);
    exp_push(0, S_STALL, 2'd0, "q_nostall_pop");
    tick(); fetch(JY, 2'b00, 8'h0D);
    exp_push(0, S_STALL, 2'd1, "q_still_full");
    exp_push(0, S_TYPE,  2'b10, "q_head_jne2");
    tick(); resolve(1'b0, 1'b0);
    tick(); resolve(1'b1, 1'b0);
    exp_push(0, S_PEND, 2'd1, "q_jcy_pend");
    exp_push(0, S_TYPE, 2'b00, "q_jcy_type");
    exp_push(0, S_LAST, 2'd0, "q_jcy_last");
    tick();
    exp_push(0, S_PEND, 2'd0, "q_drained");
    checks++;
    if (pending !== 1'b0) begin
      errors++;
      $display("FAIL d_q_drained got=%0d expected=0", pending);
    end

    tick(); fetch(JC, 2'b01, 8'h01);
    tick(); fetch(JC, 2'b01, 8'h02);
    tick(); fetch(JC, 2'b01, 8'h04); resolve(1'b1, 1'b1);
    exp_push(0, S_STALL, 2'd0, "fl_stall");
    exp_push(0, S_PT,    2'd0, "fl_pt");
    tick(); fetch(JC, 2'b01, 8'h01);
    exp_push(0, S_PEND, 2'd0, "fl_pend");
    exp_push(0, S_TYPE, 2'd0, "fl_type");
    exp_push(0, S_LAST, 2'd0, "fl_last");
    exp_push(0, S_PT,   2'd1, "fl_ctr_updated");
    tick(); resolve(1'b1, 1'b0);
    exp_push(0, S_PEND, 2'd1, "fl_refetch_pend");
    exp_push(0, S_LAST, 2'd1, "fl_refetch_last");

    tick(); resolve(1'b1, 1'b0);
    tick(); resolve(1'b1, 1'b0);
    fr(8'h00, 1'b0, 1'b0, "empty_chk");

    tick(); fetch(JC, 2'b01, 8'h03);
    tick(); fetch(JC, 2'b01, 8'h03); resolve(1'b1, 1'b0);
    exp_push(0, S_PT,    2'd0, "rbw_old");
    exp_push(0, S_STALL, 2'd0, "rbw_stall");
    tick(); fetch(JC, 2'b01, 8'h03); resolve(1'b1, 1'b0);
    exp_push(0, S_LAST, 2'd0, "rbw_last0");
    exp_push(0, S_PT,   2'd1, "rbw_new");
    tick(); resolve(1'b1, 1'b0);
    exp_push(0, S_LAST, 2'd1, "rbw_last1");
    tick();
    exp_push(0, S_PEND, 2'd0, "rbw_drained");

    tick(); fetch(JC, 2'b01, 8'h05);
    exp_push(0, S_PT, 2'd1, "r_pt05");
    tick(); fetch(JC, 2'b10, 8'h0C);
    exp_push(0, S_PT, 2'd1, "r_pt0c");
    tick(); rst_n = 1'b0; fetch(JC, 2'b01, 8'h07); resolve(1'b1, 1'b1);
    exp_push(0, S_PEND, 2'd1,  "r_pre_pend");
    exp_push(0, S_TYPE, 2'b01, "r_pre_type");
    exp_push(0, S_LAST, 2'd1,  "r_pre_last");
    tick(); rst_n = 1'b1; fetch(JC, 2'b01, 8'h05);
    exp_push(0, S_PEND,  2'd0, "r_pend");
    exp_push(0, S_TYPE,  2'd0, "r_type");
    exp_push(0, S_LAST,  2'd0, "r_last");
    exp_push(0, S_STALL, 2'd0, "r_stall");
    exp_push(0, S_PT,    2'd0, "r_ctr05");
    tick(); fetch(JC, 2'b10, 8'h0C);
    exp_push(0, S_PT,   2'd0, "r_ctr0c");
    exp_push(0, S_PEND, 2'd1, "r_pend1");
    tick(); fetch(JY, 2'b00, 8'h07);
    exp_push(0, S_STALL, 2'd1, "r_full_stall");
    tick(); resolve(1'b1, 1'b0);
    exp_push(0, S_TYPE, 2'b01, "r_head05");
    tick(); resolve(1'b1, 1'b0);
    exp_push(0, S_TYPE, 2'b10, "r_head0c");
    tick(); fetch(JC, 2'b01, 8'h05);
    exp_push(0, S_PEND, 2'd0, "r_drained");
    exp_push(0, S_PT,   2'd1, "r_ctr05_up");
    tick(); fetch(JC, 2'b01, 8'h0C);
    exp_push(0, S_PT,   2'd1, "r_ctr0c_up");

    tick(); fetch(JC, 2'b11, 8'h05);
    exp_push(0, S_PT,    2'd0, "nb_cond11_pt");
    exp_push(0, S_STALL, 2'd0, "nb_cond11_stall");
    tick(); fetch(7'h00, 2'b01, 8'h05);
    exp_push(0, S_PT, 2'd0, "nb_type_pt");
    tick(); fetch(JY, 2'b00, 8'h05); fetch_valid = 1'b0;
    exp_push(0, S_PT,   2'd0,  "nb_invalid_pt");
    exp_push(0, S_PEND, 2'd1,  "nb_pend");
    exp_push(0, S_TYPE, 2'b01, "nb_head");
    exp_push(0, S_LAST, 2'd1,  "nb_last");

    tick();
    tick();
    @(negedge clk);
    #1;
    foreach (sb[i]) begin
      checks++;
      errors++;
      $display("FAIL %s never_sampled got=none expected=%0d", sb[i].name, sb[i].val);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
